// File: rtl/dmem_vram_pkg.sv
// dmem_vram_pkg: shared FSM state type, default geometry and width helpers
// for the CPU data memory with a streamed framebuffer window.
// No ports; imported by dmem_vram and vram_prefetch_fifo.
package dmem_vram_pkg;
  typedef enum logic [1:0] {IDLE, FILL, STREAM} state_t;
  localparam int DEF_DATA_W       = 32;
  localparam int DEF_DEPTH        = 4096;
  localparam int DEF_FB_BASE      = 64;
  localparam int DEF_FB_WORDS     = 2240;
  localparam int DEF_PIX_PER_WORD = 4;
  localparam int DEF_FIFO_DEPTH   = 2;
  function automatic int pix_w(input int data_w, input int ppw);
    return data_w / ppw;
  endfunction
  function automatic int addr_w(input int depth);
    return depth > 1 ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/vram_prefetch_fifo.sv
// vram_prefetch_fifo: small synchronous FIFO holding prefetched framebuffer words.
// Ports: clk, reset (async, active-high), push/din write side, pop, flush
// (empties the FIFO and overrides push/pop), count (occupancy), head (oldest word).
module vram_prefetch_fifo
  import dmem_vram_pkg::*;
#(
  parameter int W     = DEF_DATA_W,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [W-1:0]             din,
  output logic [$clog2(DEPTH):0]   count,
  output logic [W-1:0]             head
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] slots [DEPTH];
  logic [AW-1:0] wp, rp;
  assign head = slots[rp];
  always_ff @(posedge clk)
    if (push && !flush) slots[wp] <= din;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
endmodule

// File: rtl/dmem_vram.sv
// dmem_vram: CPU data memory with a framebuffer window streamed as pixels.
// Ports: clk, reset (async, active-high); CPU side mem_write/addr/wdata/rdata
// (combinational load); video side frame_start, pix_valid/pix_ready/pix_data
// handshake, frame_busy, frame_done (one-cycle pulse after the last pixel).
// Optional: define VRAM_UNDERRUN_CNT_EN to add underrun_cnt[15:0], a saturating
// count of cycles the consumer was ready while no pixel was available.
module dmem_vram
  import dmem_vram_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int DEPTH        = DEF_DEPTH,
  parameter int FB_BASE      = DEF_FB_BASE,
  parameter int FB_WORDS     = DEF_FB_WORDS,
  parameter int PIX_PER_WORD = DEF_PIX_PER_WORD,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     mem_write,
  input  logic [31:0]                              addr,
  input  logic [DATA_W-1:0]                        wdata,
  output logic [DATA_W-1:0]                        rdata,
  input  logic                                     frame_start,
  output logic                                     pix_valid,
  input  logic                                     pix_ready,
  output logic [pix_w(DATA_W, PIX_PER_WORD)-1:0]   pix_data,
  output logic                                     frame_busy,
  output logic                                     frame_done
`ifdef VRAM_UNDERRUN_CNT_EN
  ,
  output logic [15:0]                              underrun_cnt
`endif
);
  localparam int PW = pix_w(DATA_W, PIX_PER_WORD);
  localparam int IW = addr_w(DEPTH);
  localparam int LW = addr_w(PIX_PER_WORD);
  localparam int FW = $clog2(FB_WORDS + 1);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] vdata, head;
  logic [IW-1:0] idx, ptr, fetch_addr;
  logic [FW-1:0] fetched;
  logic [LW-1:0] lane;
  logic [CW-1:0] count;
  logic in_range, inflight, issue, accept, pop, last;
  state_t state;
  assign idx = addr[IW+1:2];
  assign in_range = (addr >> (IW + 2)) == 32'd0;
  assign rdata = in_range ? mem[idx] : '0;
  // The first word is fetched in the frame_start cycle itself, which gives the
  // two-cycle latency from frame_start to the first valid pixel.
  assign fetch_addr = frame_start ? IW'(FB_BASE) : ptr;
  // Occupancy counts the in-flight read so the FIFO can never overflow.
  assign issue = state != IDLE && !frame_start
              && int'(count) + int'(inflight) < FIFO_DEPTH
              && fetched < FW'(FB_WORDS);
  assign pix_valid = count != '0;
  assign pix_data = pix_valid ? head[int'(lane)*PW +: PW] : '0;
  assign accept = pix_valid && pix_ready;
  assign pop = accept && lane == LW'(PIX_PER_WORD - 1);
  assign last = pop && count == CW'(1) && !inflight && fetched == FW'(FB_WORDS);
  assign frame_busy = state != IDLE;
  // Nonblocking read and write on the same edge make the video read see the
  // old word when the CPU stores to the address being fetched.
  always_ff @(posedge clk) begin
    if (mem_write && in_range) mem[idx] <= wdata;
    vdata <= mem[fetch_addr];
  end
  vram_prefetch_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(inflight),
    .pop(pop),
    .flush(frame_start),
    .din(vdata),
    .count(count),
    .head(head)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      ptr <= IW'(FB_BASE);
      fetched <= '0;
      lane <= '0;
      inflight <= 1'b0;
      frame_done <= 1'b0;
    end else if (frame_start) begin
      state <= FILL;
      ptr <= IW'(FB_BASE + 1);
      fetched <= FW'(1);
      lane <= '0;
      inflight <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      inflight <= issue;
      frame_done <= last;
      if (issue) begin
        ptr <= ptr + 1'b1;
        fetched <= fetched + 1'b1;
      end
      if (accept) lane <= pop ? '0 : lane + 1'b1;
      if (last) state <= IDLE;
      else if (state == FILL && inflight) state <= STREAM;
    end
`ifdef VRAM_UNDERRUN_CNT_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) underrun_cnt <= '0;
    else if (frame_start) underrun_cnt <= '0;
    else if (frame_busy && pix_ready && !pix_valid && underrun_cnt != 16'hFFFF)
      underrun_cnt <= underrun_cnt + 1'b1;
`endif
endmodule

// File: tb/tb_dmem_vram.sv
// tb_dmem_vram: directed self-checking bench for dmem_vram.
module tb_dmem_vram;
  localparam int FB_BASE = 64;
  localparam int FB_WORDS = 2240;
  localparam int NPIX = FB_WORDS * 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic mem_write = 1'b0;
  logic frame_start = 1'b0;
  logic pix_ready = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic pix_valid, frame_busy, frame_done;
  logic [7:0] pix_data;
`ifdef VRAM_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt;
`endif
  int n_checks = 0;
  int n_fails = 0;
  logic [31:0] shadow [FB_WORDS];
  logic [7:0] px_q [$];
  int done_cnt, stall_bad;
  bit timed_out;

  always #5 clk = ~clk;

  dmem_vram dut (
    .clk(clk),
    .reset(reset),
    .mem_write(mem_write),
    .addr(addr),
    .wdata(wdata),
    .rdata(rdata),
    .frame_start(frame_start),
    .pix_valid(pix_valid),
    .pix_ready(pix_ready),
    .pix_data(pix_data),
    .frame_busy(frame_busy),
    .frame_done(frame_done)
`ifdef VRAM_UNDERRUN_CNT_EN
    ,
    .underrun_cnt(underrun_cnt)
`endif
  );

  function automatic logic [7:0] exp_pix(input int i);
    logic [31:0] w;
    w = shadow[i / 4];
    return w[(i % 4) * 8 +: 8];
  endfunction

  task automatic cpu_write(input logic [31:0] a, input logic [31:0] d);
    mem_write = 1'b1;
    addr = a;
    wdata = d;
    @(posedge clk); #1;
    mem_write = 1'b0;
  endtask

  task automatic start_frame();
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask

  // Drives pix_ready and records accepted pixels; called at edge+1.
  task automatic collect(input bit bp, input int limit);
    logic [7:0] held;
    bit stalled;
    held = '0;
    stalled = 1'b0;
    px_q.delete();
    done_cnt = 0;
    stall_bad = 0;
    timed_out = 1'b0;
    for (int c = 0; c < 40000; c++) begin
      if (frame_done) begin
        done_cnt++;
        pix_ready = 1'b0;
        return;
      end
      if (px_q.size() >= limit) begin
        pix_ready = 1'b0;
        return;
      end
      if (stalled && (!pix_valid || pix_data !== held)) stall_bad++;
      pix_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      stalled = 1'b0;
      if (pix_valid && pix_ready) px_q.push_back(pix_data);
      else if (pix_valid) begin
        stalled = 1'b1;
        held = pix_data;
      end
      @(posedge clk); #1;
    end
    timed_out = 1'b1;
    pix_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk); @(posedge clk); #1;
    n_checks++; if (pix_valid !== 1'b0) begin n_fails++; $display("FAIL reset_pix_valid: got %b want 0", pix_valid); end
    n_checks++; if (frame_busy !== 1'b0) begin n_fails++; $display("FAIL reset_frame_busy: got %b want 0", frame_busy); end
    n_checks++; if (frame_done !== 1'b0) begin n_fails++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
    n_checks++; if (pix_data !== 8'h00) begin n_fails++; $display("FAIL reset_pix_data: got %h want 00", pix_data); end
`ifdef VRAM_UNDERRUN_CNT_EN
    n_checks++; if (underrun_cnt !== 16'h0) begin n_fails++; $display("FAIL reset_underrun: got %0d want 0", underrun_cnt); end
`endif
    reset = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (frame_busy !== 1'b0) begin n_fails++; $display("FAIL idle_after_reset: busy got %b want 0", frame_busy); end
  endtask

  task automatic test_cpu();
    cpu_write(32'h10, 32'hDEADBEEF);
    addr = 32'h10; #1;
    n_checks++; if (rdata !== 32'hDEADBEEF) begin n_fails++; $display("FAIL cpu_load: got %h want deadbeef", rdata); end
    addr = 32'h13; #1;
    n_checks++; if (rdata !== 32'hDEADBEEF) begin n_fails++; $display("FAIL cpu_load_unaligned: got %h want deadbeef", rdata); end
    cpu_write(32'h4010, 32'h12345678);
    addr = 32'h4010; #1;
    n_checks++; if (rdata !== 32'h0) begin n_fails++; $display("FAIL cpu_oob_load: got %h want 0", rdata); end
    addr = 32'h10; #1;
    n_checks++; if (rdata !== 32'hDEADBEEF) begin n_fails++; $display("FAIL cpu_oob_store_dropped: got %h want deadbeef", rdata); end
  endtask

  task automatic preload();
    logic [7:0] b;
    for (int i = 0; i < FB_WORDS; i++) begin
      b = 8'(i);
      shadow[i] = {b + 8'd3, b + 8'd2, b + 8'd1, b};
      cpu_write(32'((FB_BASE + i) * 4), shadow[i]);
    end
  endtask

  task automatic test_full_frame();
    pix_ready = 1'b1;
    start_frame();
    n_checks++; if (frame_busy !== 1'b1) begin n_fails++; $display("FAIL ff_busy_start: got %b want 1", frame_busy); end
    n_checks++; if (pix_valid !== 1'b0) begin n_fails++; $display("FAIL ff_latency_early: pix_valid got %b want 0", pix_valid); end
    @(posedge clk); #1;
    n_checks++; if (pix_valid !== 1'b1) begin n_fails++; $display("FAIL ff_latency: pix_valid got %b want 1", pix_valid); end
    n_checks++; if (pix_data !== exp_pix(0)) begin n_fails++; $display("FAIL ff_first_pixel: got %h want %h", pix_data, exp_pix(0)); end
    collect(1'b0, NPIX + 1);
    n_checks++; if (timed_out !== 1'b0) begin n_fails++; $display("FAIL ff_timeout: got %b want 0", timed_out); end
    n_checks++; if (px_q.size() != NPIX) begin n_fails++; $display("FAIL ff_count: got %0d want %0d", px_q.size(), NPIX); end
    for (int i = 0; i < px_q.size() && i < NPIX; i++) begin
      n_checks++;
      if (px_q[i] !== exp_pix(i)) begin n_fails++; $display("FAIL ff_pixel[%0d]: got %h want %h", i, px_q[i], exp_pix(i)); break; end
    end
    n_checks++; if (done_cnt != 1) begin n_fails++; $display("FAIL ff_done: got %0d want 1", done_cnt); end
    n_checks++; if (frame_busy !== 1'b0) begin n_fails++; $display("FAIL ff_busy_end: got %b want 0", frame_busy); end
    @(posedge clk); #1;
    n_checks++; if (frame_done !== 1'b0) begin n_fails++; $display("FAIL ff_done_pulse: got %b want 0", frame_done); end
`ifdef VRAM_UNDERRUN_CNT_EN
    n_checks++; if (underrun_cnt !== 16'd1) begin n_fails++; $display("FAIL ff_underrun: got %0d want 1", underrun_cnt); end
`endif
  endtask

  task automatic test_backpressure();
    pix_ready = 1'b0;
    start_frame();
    collect(1'b1, NPIX + 1);
    n_checks++; if (timed_out !== 1'b0) begin n_fails++; $display("FAIL bp_timeout: got %b want 0", timed_out); end
    n_checks++; if (px_q.size() != NPIX) begin n_fails++; $display("FAIL bp_count: got %0d want %0d", px_q.size(), NPIX); end
    for (int i = 0; i < px_q.size() && i < NPIX; i++) begin
      n_checks++;
      if (px_q[i] !== exp_pix(i)) begin n_fails++; $display("FAIL bp_pixel[%0d]: got %h want %h", i, px_q[i], exp_pix(i)); break; end
    end
    n_checks++; if (stall_bad != 0) begin n_fails++; $display("FAIL bp_stall_hold: got %0d unstable stalls want 0", stall_bad); end
    n_checks++; if (done_cnt != 1) begin n_fails++; $display("FAIL bp_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_restart();
    logic [7:0] want [8];
    want = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd1, 8'd2, 8'd3, 8'd4};
    pix_ready = 1'b0;
    start_frame();
    collect(1'b0, 100);
    n_checks++; if (px_q.size() != 100) begin n_fails++; $display("FAIL rs_pre_count: got %0d want 100", px_q.size()); end
    n_checks++; if (done_cnt != 0) begin n_fails++; $display("FAIL rs_pre_done: got %0d want 0", done_cnt); end
    start_frame();
    n_checks++; if (pix_valid !== 1'b0) begin n_fails++; $display("FAIL rs_flush: pix_valid got %b want 0", pix_valid); end
    n_checks++; if (frame_busy !== 1'b1) begin n_fails++; $display("FAIL rs_busy: got %b want 1", frame_busy); end
    n_checks++; if (frame_done !== 1'b0) begin n_fails++; $display("FAIL rs_no_done: got %b want 0", frame_done); end
    collect(1'b0, 8);
    n_checks++; if (px_q.size() != 8) begin n_fails++; $display("FAIL rs_count: got %0d want 8", px_q.size()); end
    for (int i = 0; i < 8 && i < px_q.size(); i++) begin
      n_checks++;
      if (px_q[i] !== want[i]) begin n_fails++; $display("FAIL rs_pixel[%0d]: got %h want %h", i, px_q[i], want[i]); end
    end
    n_checks++; if (done_cnt != 0) begin n_fails++; $display("FAIL rs_done: got %0d want 0", done_cnt); end
  endtask

  task automatic test_collision();
    logic [7:0] want [4];
    want = '{8'h44, 8'h33, 8'h22, 8'h11};
    pix_ready = 1'b0;
    start_frame();
    repeat (4) begin @(posedge clk); #1; end
    cpu_write(32'((FB_BASE + 5) * 4), 32'h11223344);
    collect(1'b0, 24);
    n_checks++; if (px_q.size() != 24) begin n_fails++; $display("FAIL col_count: got %0d want 24", px_q.size()); end
    for (int i = 0; i < 4 && 20 + i < px_q.size(); i++) begin
      n_checks++;
      if (px_q[20 + i] !== want[i]) begin n_fails++; $display("FAIL col_new[%0d]: got %h want %h", i, px_q[20 + i], want[i]); end
    end
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    mem_write = 1'b1;
    addr = 32'((FB_BASE + 1) * 4);
    wdata = 32'hA5A5A5A5;
    @(posedge clk); #1;
    mem_write = 1'b0;
    #1;
    n_checks++; if (rdata !== 32'hA5A5A5A5) begin n_fails++; $display("FAIL col_same_store: got %h want a5a5a5a5", rdata); end
    collect(1'b0, 8);
    n_checks++; if (px_q.size() != 8) begin n_fails++; $display("FAIL col_same_count: got %0d want 8", px_q.size()); end
    for (int i = 4; i < 8 && i < px_q.size(); i++) begin
      n_checks++;
      if (px_q[i] !== 8'(i - 3)) begin n_fails++; $display("FAIL col_same_old[%0d]: got %h want %h", i, px_q[i], 8'(i - 3)); end
    end
  endtask

  task automatic test_reset_mid();
    pix_ready = 1'b0;
    start_frame();
    collect(1'b0, 50);
    reset = 1'b1;
    #1;
    n_checks++; if (pix_valid !== 1'b0) begin n_fails++; $display("FAIL rm_pix_valid: got %b want 0", pix_valid); end
    n_checks++; if (frame_busy !== 1'b0) begin n_fails++; $display("FAIL rm_frame_busy: got %b want 0", frame_busy); end
    n_checks++; if (pix_data !== 8'h00) begin n_fails++; $display("FAIL rm_pix_data: got %h want 00", pix_data); end
`ifdef VRAM_UNDERRUN_CNT_EN
    n_checks++; if (underrun_cnt !== 16'h0) begin n_fails++; $display("FAIL rm_underrun: got %0d want 0", underrun_cnt); end
`endif
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    n_checks++; if (frame_busy !== 1'b0) begin n_fails++; $display("FAIL rm_idle_busy: got %b want 0", frame_busy); end
    n_checks++; if (pix_valid !== 1'b0) begin n_fails++; $display("FAIL rm_idle_valid: got %b want 0", pix_valid); end
    pix_ready = 1'b1;
    start_frame();
    @(posedge clk); #1;
    n_checks++; if (pix_valid !== 1'b1) begin n_fails++; $display("FAIL rm_restart_valid: got %b want 1", pix_valid); end
    n_checks++; if (pix_data !== exp_pix(0)) begin n_fails++; $display("FAIL rm_restart_pixel: got %h want %h", pix_data, exp_pix(0)); end
`ifdef VRAM_UNDERRUN_CNT_EN
    n_checks++; if (underrun_cnt !== 16'd1) begin n_fails++; $display("FAIL rm_underrun_count: got %0d want 1", underrun_cnt); end
`endif
    pix_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_cpu();
    preload();
    test_full_frame();
    test_backpressure();
    test_restart();
    test_collision();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/dmem_vram.md
Name: dmem_vram

Overview:
Parametrised successor to the processor data memory. It keeps the single-cycle ARM load/store port and replaces the flat whole-array texture export with a framebuffer window. That window is streamed to the display pipeline through a prefetching valid/ready pixel port. Sits between arm, the VGA pixel generator and top; all on one clock.

Parameters:
DATA_W, 32, CPU word width in bits
DEPTH, 4096, memory depth in words (power of two)
FB_BASE, 64, word index of the first framebuffer word
FB_WORDS, 2240, framebuffer length in words; FB_BASE+FB_WORDS <= DEPTH
PIX_PER_WORD, 4, pixels packed per word; PIX_W = DATA_W/PIX_PER_WORD
FIFO_DEPTH, 2, prefetch buffer entries (power of two, >=2)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
mem_write  in  1  CPU store enable
addr  in  32  CPU byte address; word index = addr[$clog2(DEPTH)+1:2]
wdata  in  DATA_W  CPU store data
rdata  out  DATA_W  CPU load data, combinational
frame_start  in  1  one-cycle pulse: begin streaming a frame
pix_valid  out  1  pix_data holds a valid pixel
pix_ready  in  1  consumer accepts pixel
pix_data  out  PIX_W  current pixel
frame_busy  out  1  frame streaming in progress
frame_done  out  1  one-cycle pulse after the last pixel is accepted

Behaviour:
- Reset (async): state IDLE, FIFO empty, fetch pointer FB_BASE, lane 0, pix_valid/frame_busy/frame_done = 0, pix_data = 0. Memory contents are not reset.
- CPU store: at posedge clk with mem_write=1, mem[idx] <= wdata. addr[1:0] is ignored.
- CPU load: rdata = mem[idx] combinationally, zero latency. Addresses with bits above the index nonzero give rdata = 0, and stores to them are dropped.
- Video port read is registered with 1-cycle latency. It is read-before-write: if the CPU writes the word being fetched in the same cycle, the FIFO receives the old value.
- FSM IDLE -> FILL -> STREAM -> IDLE:
  - IDLE: on frame_start, flush FIFO, ptr=FB_BASE, fetched=0, lane=0, go to FILL.
  - FILL and STREAM: issue a fetch each cycle where (FIFO count + in-flight) < FIFO_DEPTH and fetched < FB_WORDS. ptr increments per fetch.
  - FILL -> STREAM on the first FIFO entry.
  - pix_valid = FIFO non-empty. pix_data = head word bits [lane*PIX_W +: PIX_W], lane 0 = LSBs first.
  - On pix_valid&pix_ready: lane++. At lane PIX_PER_WORD-1 the lane wraps to 0 and the head is popped.
  - Once fetched==FB_WORDS and the last pixel is accepted: frame_done=1 for one cycle, go to IDLE.
- frame_busy = (state != IDLE).
- frame_start while busy: restart. Flush the FIFO, discard any in-flight fetch result, reset ptr/lane, and do not assert frame_done.
- pix_valid stays low when empty. pix_data is held while pix_valid&!pix_ready.
- Throughput: one pixel per cycle sustained after a 2-cycle initial fill latency (frame_start to first pix_valid).

Optional Feature:
VRAM_UNDERRUN_CNT_EN:
- When defined, add output underrun_cnt [15:0]. It increments (saturating at 16'hFFFF) each cycle pix_ready=1 and pix_valid=0 while frame_busy, and clears on reset and frame_start.
- When undefined, the port and logic are absent.

Decomposition:
- Package dmem_vram_pkg: FSM state enum (IDLE, FILL, STREAM), default parameter constants, PIX_W/ADDR_W helper functions.
- Sub-module vram_prefetch_fifo: parametrised sync FIFO (push, pop, flush, count, head word). The top module holds the array, CPU port, FSM and lane mux.

Test Plan:
1. CPU store/load: write 32'hDEADBEEF to addr 0x10 -> rdata at addr 0x10 = 32'hDEADBEEF in the same cycle after the edge; addr 0x10|0x3 reads the same word.
2. Full frame, pix_ready=1:
   - Stimulus: FB words preloaded with word i = {i[7:0]+3, i[7:0]+2, i[7:0]+1, i[7:0]}, then frame_start.
   - Response: 8960 pixels in order 0,1,2,3,1,2,...; first pix_valid 2 cycles after frame_start; single frame_done; frame_busy low next cycle.
3. Backpressure: pix_ready toggled 1/0 randomly -> identical pixel sequence, pix_data stable while stalled, no loss or duplication.
4. Restart: frame_start at pixel 100 -> next accepted pixel is word FB_BASE lane 0, no frame_done for the aborted frame.
5. Write collision: CPU writes 32'h11223344 to FB_BASE+5 while streaming, before that word's fetch -> streamed lanes 44,33,22,11. In the same-cycle case, old data is streamed.
6. Reset mid-frame: assert reset during STREAM -> pix_valid/frame_busy drop immediately; after release, IDLE until frame_start. With VRAM_UNDERRUN_CNT_EN, underrun_cnt=0.
